// File: rtl/data_bus_arbiter_if.sv
// data_bus_arbiter_if: one data-bus port (access type NONE=0 R=1 W=2 X=3, length B=0 H=1 W=2).
interface data_bus_arbiter_if;
  logic [31:0] addr, data_out, data_in;
  logic [1:0] access_type, mem_len;
  logic ready, err;
  modport master(output addr, data_out, access_type, mem_len, input data_in, ready);
  modport slave(input addr, data_out, access_type, mem_len, output data_in, ready, err);
endinterface

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: two-master data bus arbiter with watchdog; DATA_BUS_ARB_RR_EN selects round-robin ties.
module data_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 9
) (
  input logic clk,
  input logic res,
  data_bus_arbiter_if.slave m0,
  data_bus_arbiter_if.slave m1,
  data_bus_arbiter_if.master db
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic owner, last_grant, req0, req1, win, done;
  logic [31:0] req_addr, req_data, ret_data;
  logic [1:0] req_type, req_len;
  assign req0 = m0.access_type != 2'd0;
  assign req1 = m1.access_type != 2'd0;
`ifdef DATA_BUS_ARB_RR_EN
  assign win = req0 && req1 ? !last_grant : req1;
`else
  assign win = !req0;
`endif
  // a same-cycle db_ready beats watchdog expiry
  assign done = db.ready || cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign ret_data = db.ready ? db.data_in : '0;
  // req_* are zero outside BUSY, so the slave bus idles at NONE
  assign db.addr = req_addr;
  assign db.data_out = req_data;
  assign db.access_type = req_type;
  assign db.mem_len = req_len;
  always_ff @(posedge clk) begin
    if (!res) begin
      state <= IDLE;
      cnt <= '0;
      owner <= 1'b0;
      last_grant <= 1'b1;
      {req_addr, req_data, req_type, req_len} <= '0;
      {m0.ready, m0.err, m1.ready, m1.err} <= '0;
      m0.data_in <= '0;
      m1.data_in <= '0;
    end else begin
      {m0.ready, m0.err, m1.ready, m1.err} <= '0;
      case (state)
        IDLE: if (req0 || req1) begin
          state <= BUSY;
          owner <= win;
          last_grant <= win;
          cnt <= '0;
          req_addr <= win ? m1.addr : m0.addr;
          req_data <= win ? m1.data_out : m0.data_out;
          req_type <= win ? m1.access_type : m0.access_type;
          req_len <= win ? m1.mem_len : m0.mem_len;
        end
        BUSY: if (done) begin
          state <= RESP;
          {req_addr, req_data, req_type, req_len} <= '0;
          if (owner) begin
            m1.ready <= 1'b1;
            m1.err <= !db.ready;
            m1.data_in <= ret_data;
          end else begin
            m0.ready <= 1'b1;
            m0.err <= !db.ready;
            m0.data_in <= ret_data;
          end
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed checks of arbitration, wait states, timeout and reset.
module tb_data_bus_arbiter;
  logic clk = 1'b0, res = 1'b0;
  int n_checks = 0, n_errors = 0;
  data_bus_arbiter_if m0(), m1(), db(), t0(), t1(), tdb();
  data_bus_arbiter dut (.clk(clk), .res(res), .m0(m0), .m1(m1), .db(db));
  data_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (.clk(clk), .res(res), .m0(t0), .m1(t1), .db(tdb));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    res = 1'b0;
    tick;
    tick;
    res = 1'b1;
  endtask
  task automatic drive_m0(input logic [1:0] t, input logic [1:0] l, input logic [31:0] a, input logic [31:0] d);
    m0.access_type = t; m0.mem_len = l; m0.addr = a; m0.data_out = d;
  endtask
  task automatic drive_m1(input logic [1:0] t, input logic [1:0] l, input logic [31:0] a, input logic [31:0] d);
    m1.access_type = t; m1.mem_len = l; m1.addr = a; m1.data_out = d;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    int exp_owner;
    drive_m0(2'd1, 2'd2, 32'h0, 32'h0);
    drive_m1(2'd1, 2'd2, 32'h4, 32'h0);
    {t0.access_type, t0.mem_len, t0.addr, t0.data_out} = '0;
    {t1.access_type, t1.mem_len, t1.addr, t1.data_out} = '0;
    db.ready = 1'b0; db.data_in = '0; db.err = 1'b0;
    tdb.ready = 1'b0; tdb.data_in = '0; tdb.err = 1'b0;
    // reset held with both masters requesting
    for (int i = 0; i < 2; i++) begin
      tick;
      check("rst_db_type", db.access_type, 2'd0);
      check("rst_db_addr", db.addr, 32'h0);
      check("rst_m0_ready", m0.ready, 1'b0);
      check("rst_m1_ready", m1.ready, 1'b0);
      check("rst_m0_data", m0.data_in, 32'h0);
    end
    drive_m0(2'd0, 2'd0, 32'h0, 32'h0);
    drive_m1(2'd0, 2'd0, 32'h0, 32'h0);
    res = 1'b1;
    tick;
    check("idle_db_type", db.access_type, 2'd0);
    // single read, slave always ready
    drive_m0(2'd1, 2'd2, 32'h100, 32'h0);
    db.ready = 1'b1; db.data_in = 32'hDEADBEEF;
    tick;
    drive_m0(2'd0, 2'd0, 32'h0, 32'h0);
    check("rd_db_addr", db.addr, 32'h100);
    check("rd_db_type", db.access_type, 2'd1);
    check("rd_db_len", db.mem_len, 2'd2);
    tick;
    check("rd_m0_ready", m0.ready, 1'b1);
    check("rd_m0_data", m0.data_in, 32'hDEADBEEF);
    check("rd_m0_err", m0.err, 1'b0);
    check("rd_m1_ready", m1.ready, 1'b0);
    check("rd_db_idle", db.access_type, 2'd0);
    tick;
    check("rd_m0_ready_low", m0.ready, 1'b0);
    check("rd_db_none", db.access_type, 2'd0);
    db.ready = 1'b0;
    // contention: both hold requests for 4 transactions
    do_reset;
    drive_m0(2'd1, 2'd2, 32'h10, 32'h0);
    drive_m1(2'd1, 2'd2, 32'h20, 32'h0);
    db.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef DATA_BUS_ARB_RR_EN
      exp_owner = i % 2;
`else
      exp_owner = 0;
`endif
      db.data_in = 32'hA000 + i;
      tick;
      check($sformatf("arb%0d_addr", i), db.addr, exp_owner == 1 ? 32'h20 : 32'h10);
      tick;
      check($sformatf("arb%0d_m0_ready", i), m0.ready, exp_owner == 0);
      check($sformatf("arb%0d_m1_ready", i), m1.ready, exp_owner == 1);
      check($sformatf("arb%0d_data", i), exp_owner == 1 ? m1.data_in : m0.data_in, 32'hA000 + i);
      tick;
    end
    drive_m0(2'd0, 2'd0, 32'h0, 32'h0);
    drive_m1(2'd0, 2'd0, 32'h0, 32'h0);
    db.ready = 1'b0;
    // m1 byte write, db_ready in the 6th BUSY cycle; m0 requests meanwhile
    do_reset;
    drive_m1(2'd2, 2'd0, 32'h20, 32'h5A);
    tick;
    drive_m1(2'd0, 2'd0, 32'h0, 32'h0);
    drive_m0(2'd1, 2'd2, 32'h999, 32'h0);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("ws%0d_addr", c), db.addr, 32'h20);
      check($sformatf("ws%0d_wdata", c), db.data_out, 32'h5A);
      check($sformatf("ws%0d_type", c), db.access_type, 2'd2);
      check($sformatf("ws%0d_len", c), db.mem_len, 2'd0);
      check($sformatf("ws%0d_m1_ready", c), m1.ready, 1'b0);
      if (c == 5) begin
        db.ready = 1'b1; db.data_in = 32'h77;
      end
      tick;
    end
    db.ready = 1'b0;
    check("ws_m1_ready", m1.ready, 1'b1);
    check("ws_m1_err", m1.err, 1'b0);
    check("ws_m0_ready", m0.ready, 1'b0);
    drive_m0(2'd0, 2'd0, 32'h0, 32'h0);
    tick;
    check("ws_m1_single_pulse", m1.ready, 1'b0);
    check("ws_m0_not_granted", m0.ready, 1'b0);
    // timeout instance: db_ready in the 4th BUSY cycle wins
    do_reset;
    t0.access_type = 2'd1; t0.mem_len = 2'd2; t0.addr = 32'h44;
    tick;
    t0.access_type = 2'd0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("to_late%0d_type", c), tdb.access_type, 2'd1);
      tick;
    end
    tdb.ready = 1'b1; tdb.data_in = 32'h1234;
    tick;
    tdb.ready = 1'b0;
    check("to_late_ready", t0.ready, 1'b1);
    check("to_late_err", t0.err, 1'b0);
    check("to_late_data", t0.data_in, 32'h1234);
    tick;
    // slave never ready: abort after exactly 4 BUSY cycles
    t0.access_type = 2'd1;
    tick;
    t0.access_type = 2'd0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("to%0d_type", c), tdb.access_type, 2'd1);
      check($sformatf("to%0d_ready", c), t0.ready, 1'b0);
      tick;
    end
    check("to_ready", t0.ready, 1'b1);
    check("to_err", t0.err, 1'b1);
    check("to_data", t0.data_in, 32'h0);
    check("to_db_idle", tdb.access_type, 2'd0);
    tick;
    check("to_ready_low", t0.ready, 1'b0);
    // reset in the middle of BUSY drops the access
    do_reset;
    drive_m0(2'd1, 2'd2, 32'h300, 32'h0);
    tick;
    drive_m0(2'd0, 2'd0, 32'h0, 32'h0);
    tick;
    res = 1'b0;
    tick;
    check("mid_db_type", db.access_type, 2'd0);
    check("mid_m0_ready", m0.ready, 1'b0);
    res = 1'b1;
    tick;
    check("mid_no_pulse", m0.ready, 1'b0);
    drive_m0(2'd1, 2'd2, 32'h300, 32'h0);
    db.ready = 1'b1; db.data_in = 32'hCAFE;
    tick;
    drive_m0(2'd0, 2'd0, 32'h0, 32'h0);
    check("reissue_addr", db.addr, 32'h300);
    tick;
    check("reissue_ready", m0.ready, 1'b1);
    check("reissue_data", m0.data_in, 32'hCAFE);
    check("reissue_err", m0.err, 1'b0);
    db.ready = 1'b0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
